// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg: shared state type, AXI response codes and default widths for mem_reader
package mem_reader_pkg;
  localparam int MR_DATA_W = 32;
  localparam int MR_ADDR_W = 9;
  localparam int MR_FIFO_DEPTH = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} mr_state_t;
endpackage

// File: rtl/mr_fifo.sv
// mr_fifo: synchronous FIFO whose head entry is read straight from storage registers
module mr_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // a pop frees the head slot in the same cycle, so a full FIFO may accept a push alongside it
  always_comb begin
    do_pop = pop_i && cnt_q != '0;
    do_push = push_i && (!cnt_q[AW] || do_pop);
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    pop_data_o = mem_q[rd_q];
    full_o = cnt_q[AW];
    empty_o = cnt_q == '0;
    count_o = cnt_q;
  end
  // storage, pointers and occupancy; storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= push_data_i;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_reader.sv
// mem_reader: AXI4-Lite block reader streaming words out through a small FIFO; MEM_READER_LOOP_EN adds continuous looping with a stop input
module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int DATA_W = MR_DATA_W,
  parameter int ADDR_W = MR_ADDR_W,
  parameter int FIFO_DEPTH = MR_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
`ifdef MEM_READER_LOOP_EN
  input  logic              stop,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  mr_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] rem_q, rem_d;
  logic err_q, err_d, done_q, done_d;
  logic fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic push, pop, last_beat;
`ifdef MEM_READER_LOOP_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0] len_q, len_d;
  logic stop_q, stop_d;
`endif
  mr_fifo #(
    .W(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(push),
    .push_data_i(rdata),
    .pop_i(pop),
    .pop_data_o(out_data),
    .full_o(fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );
  // state and transfer bookkeeping registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
`ifdef MEM_READER_LOOP_EN
  // region reload values and the pending stop request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      len_q <= '0;
      stop_q <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q <= len_d;
      stop_q <= stop_d;
    end
  end
`endif
  // next state: one outstanding read, FIFO slot checked before each address phase
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    err_d = err_q;
    done_d = 1'b0;
`ifdef MEM_READER_LOOP_EN
    base_d = base_q;
    len_d = len_q;
    stop_d = stop_q | stop;
`endif
    last_beat = rem_q == {{ADDR_W{1'b0}}, 1'b1};
    unique case (state_q)
      IDLE: if (start) begin
        err_d = 1'b0;
        done_d = count == '0;
        if (count != '0) begin
          state_d = ADDR;
          addr_d = base_addr;
          rem_d = count;
`ifdef MEM_READER_LOOP_EN
          base_d = base_addr;
          len_d = count;
          stop_d = 1'b0;
`endif
        end
      end
      ADDR: if (arvalid && arready) state_d = DATA;
      DATA: if (rvalid) begin
        err_d = err_q | (rresp != RESP_OKAY);
        rem_d = rem_q - 1'b1;
        addr_d = addr_q + 1'b1;
`ifdef MEM_READER_LOOP_EN
        state_d = stop_d ? DRAIN : ADDR;
        if (!stop_d && last_beat) begin
          addr_d = base_q;
          rem_d = len_q;
        end
`else
        state_d = last_beat ? DRAIN : ADDR;
`endif
      end
      DRAIN: if (fifo_cnt == '0) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    endcase
  end
  // AXI handshakes, stream control and status derived from the current state
  always_comb begin
    arvalid = state_q == ADDR && !fifo_full;
    rready = state_q == DATA;
    busy = state_q != IDLE;
    araddr = addr_q;
    err = err_q;
    done = done_q;
    out_valid = !fifo_empty;
    push = rready && rvalid;
    pop = out_valid && out_ready;
  end
endmodule

// File: tb/tb_mem_reader.sv
// tb_mem_reader: directed bench for mem_reader with a zero-wait AXI read memory model
module tb_mem_reader;
  import mem_reader_pkg::*;
  localparam int AW = 9;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] count = '0;
  logic busy, done, err, arvalid, rready, out_valid;
  logic [AW-1:0] araddr;
  logic arready = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic [1:0] rresp = 2'b00;
  logic rvalid = 1'b0;
  logic [DW-1:0] out_data;
  logic out_ready = 1'b1;
`ifdef MEM_READER_LOOP_EN
  logic stop = 1'b0;
`endif
  logic [DW-1:0] mem [512];
  logic [AW-1:0] err_addr = '0;
  logic err_en = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int cyc;
  logic [AW-1:0] ar_q [$];
  logic [DW-1:0] out_q [$];
  logic prev_arv = 1'b0;
  logic prev_rhs = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always #5 clk = ~clk;

  mem_reader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .count(count),
`ifdef MEM_READER_LOOP_EN
    .stop(stop),
`endif
    .busy(busy),
    .done(done),
    .err(err),
    .araddr(araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata),
    .rresp(rresp),
    .rvalid(rvalid),
    .rready(rready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    ar_q.delete();
    out_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
    base_addr = b;
    count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
  endtask

  // memory responder: one beat returned the cycle after each address handshake
  always @(posedge clk or posedge reset)
    if (reset) begin
      rvalid <= 1'b0;
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (rvalid && rready) rvalid <= 1'b0;
    else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata <= mem[araddr];
      rresp <= (err_en && araddr == err_addr) ? RESP_SLVERR : RESP_OKAY;
    end

  // bus monitor on the falling edge: logs handshakes, checks arvalid hold and push-to-valid latency
  always @(negedge clk) begin
    if (reset) begin
      prev_arv = 1'b0;
      prev_rhs = 1'b0;
    end else begin
      if (prev_arv) begin
        chk("ar_hold_valid", arvalid, 1);
        chk("ar_hold_addr", araddr, prev_addr);
      end
      if (prev_rhs) chk("r_to_out_valid", out_valid, 1);
      if (arvalid && arready) ar_q.push_back(araddr);
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (done) done_cnt++;
      prev_arv = arvalid && !arready;
      prev_addr = araddr;
      prev_rhs = rvalid && rready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hDEAD_0000 | i;
    for (int k = 0; k < 4; k++) mem[9'h010 + k] = 32'hA0 + k;
    for (int k = 0; k < 8; k++) mem[9'h040 + k] = 32'hB0 + k;
    mem[9'h1FE] = 32'hC0;
    mem[9'h1FF] = 32'hC1;
    mem[9'h000] = 32'hC2;
    mem[9'h001] = 32'hC3;
    for (int k = 0; k < 3; k++) mem[9'h080 + k] = 32'hD0 + k;
    for (int k = 0; k < 6; k++) mem[9'h100 + k] = 32'hE0 + k;
    #1 reset = 1'b1;
    tick(2);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;
    tick();
    // single pass, zero-wait memory, consumer always ready
    clr();
    chk("idle_arvalid", arvalid, 0);
    do_start(9'h010, 4);
    chk("busy_after_start", busy, 1);
    chk("arvalid_after_start", arvalid, 1);
    wait_done(100, cyc);
    chk("single_cycles", cyc, 10);
    tick();
    chk("done_one_cycle", done, 0);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_err", err, 0);
    chk("single_ar_n", ar_q.size(), 4);
    chk("single_out_n", out_q.size(), 4);
    for (int i = 0; i < 4 && i < ar_q.size(); i++) chk("single_araddr", ar_q[i], 32'h010 + i);
    for (int i = 0; i < 4 && i < out_q.size(); i++) chk("single_data", out_q[i], 32'hA0 + i);
    // back-pressure: only FIFO_DEPTH reads may be outstanding in the FIFO
    clr();
    out_ready = 1'b0;
    do_start(9'h040, 8);
    tick(20);
    chk("bp_ar_n", ar_q.size(), 4);
    chk("bp_arvalid_low", arvalid, 0);
    chk("bp_busy", busy, 1);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, 32'hB0);
    out_ready = 1'b1;
    wait_done(200, cyc);
    tick();
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_ar_total", ar_q.size(), 8);
    chk("bp_out_n", out_q.size(), 8);
    for (int i = 0; i < 8 && i < out_q.size(); i++) chk("bp_data", out_q[i], 32'hB0 + i);
    // address wrap, with arready stalled so the held address is observed
    clr();
    arready = 1'b0;
    do_start(9'h1FE, 4);
    tick(3);
    arready = 1'b1;
    wait_done(100, cyc);
    tick();
    chk("wrap_ar_n", ar_q.size(), 4);
    if (ar_q.size() == 4) begin
      chk("wrap_a0", ar_q[0], 32'h1FE);
      chk("wrap_a1", ar_q[1], 32'h1FF);
      chk("wrap_a2", ar_q[2], 32'h000);
      chk("wrap_a3", ar_q[3], 32'h001);
    end
    chk("wrap_out_n", out_q.size(), 4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) chk("wrap_data", out_q[i], 32'hC0 + i);
    // slave error on the middle word: sticky err, all data still delivered
    clr();
    err_addr = 9'h081;
    err_en = 1'b1;
    do_start(9'h080, 3);
    wait_done(100, cyc);
    tick();
    err_en = 1'b0;
    chk("slverr_err", err, 1);
    chk("slverr_out_n", out_q.size(), 3);
    for (int i = 0; i < 3 && i < out_q.size(); i++) chk("slverr_data", out_q[i], 32'hD0 + i);
    tick(3);
    chk("slverr_sticky", err, 1);
    // zero-length start: clears err, done next cycle, no bus activity
    clr();
    do_start(9'h055, 0);
    chk("zero_done", done, 1);
    chk("zero_err_clr", err, 0);
    chk("zero_busy", busy, 0);
    chk("zero_arvalid", arvalid, 0);
    tick();
    chk("zero_done_fall", done, 0);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_ar_n", ar_q.size(), 0);
    // reset in the middle of a six-word transfer
    clr();
    do_start(9'h100, 6);
    for (int i = 0; i < 100 && out_q.size() < 2; i++) tick();
    chk("mid_two_words", out_q.size(), 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    tick();
    reset = 1'b0;
    tick();
    clr();
    do_start(9'h100, 6);
    wait_done(100, cyc);
    tick();
    chk("post_rst_done_cnt", done_cnt, 1);
    chk("post_rst_out_n", out_q.size(), 6);
    if (ar_q.size() > 0) chk("post_rst_first_addr", ar_q[0], 32'h100);
    for (int i = 0; i < 6 && i < out_q.size(); i++) chk("post_rst_data", out_q[i], 32'hE0 + i);
`ifdef MEM_READER_LOOP_EN
    // continuous loop over two words until stop
    clr();
    do_start(9'h010, 2);
    for (int i = 0; i < 100 && out_q.size() < 5; i++) tick();
    chk("loop_no_done", done_cnt, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(100, cyc);
    tick();
    chk("loop_done_cnt", done_cnt, 1);
    chk("loop_min_words", out_q.size() >= 5, 1);
    for (int i = 0; i < out_q.size(); i++) chk("loop_data", out_q[i], 32'hA0 + (i % 2));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_reader.md
# mem_reader

AXI4-Lite read initiator that fetches a block of 32-bit words from the shared memory and hands them out as a valid/ready sample stream. It is the read-back counterpart of the sample-write path: software or the testbench sets a base address and a word count, and the block drains that region of memory into a downstream consumer. It sits beside the AXI memory as a second initiator on its read channels, with a small internal FIFO decoupling memory latency from consumer back-pressure.

## Interface
- DATA_W, 32, data width of memory words and stream
- ADDR_W, 9, word address width; wraps modulo 2^ADDR_W
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; ignored while busy
- base_addr  in  ADDR_W  first word address, sampled on start
- count  in  ADDR_W+1  words to read, sampled on start; 0 is legal
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word has left the FIFO
- err  out  1  sticky; set by any non-OKAY rresp, cleared by the next accepted start
- araddr  out  ADDR_W  read word address
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- out_data  out  DATA_W  stream data (FIFO head)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready

## Operation
- FSM states: IDLE, ADDR, DATA, DRAIN.
- IDLE: start with count != 0 -> latch base_addr/count, clear err, go to ADDR. start with count == 0 -> pulse done next cycle, stay IDLE, no bus activity.
- ADDR: arvalid = 1 only when the FIFO has at least one free slot; once asserted, arvalid and araddr are held stable until arready. On handshake -> DATA.
- DATA: rready = 1. On rvalid, push rdata into the FIFO and set err if rresp != 2'b00; data is pushed even on error. Then decrement remaining; increment araddr modulo 2^ADDR_W; remaining == 0 -> DRAIN, else ADDR.
- DRAIN: wait for FIFO empty, pulse done, go to IDLE.
- One outstanding read at a time. FIFO space is reserved before arvalid is asserted, so the push in DATA never overflows.
- FIFO: pop on out_valid && out_ready. Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- start in any state other than IDLE is ignored.
- Reset mid-transfer: all state is cleared immediately and any in-flight AXI beat is discarded. The memory shares this reset domain.

## Timing
- Reset values: arvalid = 0, rready = 0, araddr = 0, busy = 0, done = 0, err = 0, out_valid = 0, out_data = 0.
- arvalid rises at the earliest in the cycle after start.
- With zero-wait memory and out_ready held high, throughput is 1 word per 2 cycles.
- Latency from the rvalid&&rready edge to out_valid is 1 cycle (registered FIFO output).
- done asserts 1 cycle after the FIFO becomes empty in DRAIN. busy falls in the same cycle that done rises.

## Configuration
- MEM_READER_LOOP_EN defined:
  - Adds input port stop (1 bit).
  - After the last word, the block reloads base_addr/count and returns to ADDR instead of DRAIN, streaming the region continuously.
  - stop is sampled in any state; the current beat completes, then the block enters DRAIN.
  - done pulses only after stop.
- Undefined: port stop is absent and the block performs a single pass.

## Structure
- Package mem_reader_pkg holds:
  - the state enum typedef mr_state_t
  - AXI response constants RESP_OKAY, RESP_SLVERR
  - the default width localparams
- One sub-module, mr_fifo: synchronous FIFO with registered output, and full/empty/count outputs.

## Test plan
- Single pass: base 0x010, count 4, memory holds 0xA0..0xA3, out_ready = 1 -> araddr sequence 0x010..0x013, stream 0xA0..0xA3, one done pulse, err = 0.
- Back-pressure: count 8, out_ready = 0 for 20 cycles -> exactly FIFO_DEPTH reads issued, then arvalid stays low; releasing out_ready yields all 8 words in order with none lost.
- Address wrap: base 0x1FE, count 4 -> araddr sequence 0x1FE, 0x1FF, 0x000, 0x001.
- Error and zero count:
  - rresp = SLVERR on word 2 of 3 -> err sticks high, and all 3 words are still delivered.
  - Next start with count 0 -> err cleared, done pulses 1 cycle later, no arvalid.
- Reset mid-transfer: assert reset after 2 of 6 words -> all outputs at reset values; a new start reads correctly from base.
- With MEM_READER_LOOP_EN: count 2 -> sequence repeats A,B,A,B; stop asserted -> the in-flight word is delivered, then done.
